multi_bank_pp_buffer: RTL and testbench



---
 rtl/top_pkg.sv | 20 ++
 rtl/pp_bank_ram.sv | 26 ++
 rtl/multi_bank_pp_buffer.sv | 252 +++++++++++++++++++++++++
 tb/tb_multi_bank_pp_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/top_pkg.sv
// Shared types and helpers for the multi-bank ping-pong buffer.
package top_pkg;

    localparam int TOP_CHUNK_SIZE = 1;

    typedef enum logic [1:0] {
        EMPTY,
        FILLING,
        FULL,
        DRAINING
    } bank_state_t;

    // A replay count of 0 still drains the bank once; oversize requests saturate.
    function automatic int unsigned clamp_passes(input int unsigned cfg, input int unsigned max_passes);
        if (cfg == 0) return 1;
        if (cfg > max_passes) return max_passes;
        return cfg;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port (1-cycle latency).
module pp_bank_ram #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // NOTE: storage has no reset; a bank is always rewritten before it is read, and a reset would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/multi_bank_pp_buffer.sv
// N-bank ping-pong buffer: serialises wide producer beats into bank RAMs and replays each full bank to the consumer.
module multi_bank_pp_buffer
    import top_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int CHUNK_SIZE    = TOP_CHUNK_SIZE,
    parameter int NUM_CORES_A   = 2,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 4,
    parameter int DEPTH         = 16,
    parameter int NUM_BANKS     = 2,
    parameter int MAX_PASSES    = 4,
    localparam int MODULE_WIDTH = WIDTH * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B,
    localparam int IN_WIDTH     = MODULE_WIDTH * TOTAL_MODULES,
    localparam int ADDR_WIDTH   = $clog2(DEPTH),
    localparam int BANK_W       = $clog2(NUM_BANKS),
    localparam int PASS_W       = $clog2(MAX_PASSES + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    output logic                    wr_ready,
    input  logic [IN_WIDTH-1:0]     wr_data,
    input  logic [PASS_W-1:0]       cfg_passes,
    output logic                    rd_valid,
    input  logic                    rd_ready,
    output logic [MODULE_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [PASS_W-1:0]       rd_pass,
    output logic                    rd_last,
    output logic [BANK_W-1:0]       active_bank_wr,
    output logic [BANK_W-1:0]       active_bank_rd,
    output logic [BANK_W:0]         banks_full
);

    localparam int SER_W = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [PASS_W-1:0]     pass;
        logic                  last;
    } rd_meta_t;

    typedef struct packed {
        logic [MODULE_WIDTH-1:0] data;
        rd_meta_t                meta;
    } rd_word_t;

    function automatic logic [BANK_W-1:0] next_bank(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(NUM_BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    bank_state_t             bank_state_q [NUM_BANKS], bank_state_d [NUM_BANKS];
    logic [PASS_W-1:0]       bank_passes_q [NUM_BANKS], bank_passes_d [NUM_BANKS];
    logic [IN_WIDTH-1:0]     beat_q, beat_d;
    logic                    ser_busy_q, ser_busy_d;
    logic [SER_W-1:0]        ser_idx_q, ser_idx_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [BANK_W-1:0]       wr_bank_q, wr_bank_d;
    logic                    iss_active_q, iss_active_d;
    logic [ADDR_WIDTH-1:0]   iss_addr_q, iss_addr_d;
    logic [PASS_W-1:0]       iss_pass_q, iss_pass_d;
    logic [BANK_W-1:0]       iss_bank_q, iss_bank_d;
    logic [BANK_W-1:0]       rd_bank_q, rd_bank_d;
    logic                    pend_valid_q, pend_valid_d;
    rd_meta_t                pend_q, pend_d;
    logic [BANK_W-1:0]       pend_bank_q, pend_bank_d;
    rd_word_t                skid_q [2], skid_d [2];
    logic [1:0]              skid_cnt_q, skid_cnt_d;

    logic                    wr_accept, issue, pop, last_pop;
    logic [2:0]              occupancy;
    logic [PASS_W-1:0]       cur_passes;
    logic [MODULE_WIDTH-1:0] ram_wdata;
    logic [MODULE_WIDTH-1:0] ram_rdata [NUM_BANKS];
    rd_word_t                push_word;

    assign wr_ready  = rst_n && !ser_busy_q &&
                       (bank_state_q[wr_bank_q] == EMPTY || bank_state_q[wr_bank_q] == FILLING);
    assign wr_accept = wr_valid && wr_ready;
    assign ram_wdata = beat_q[ser_idx_q * MODULE_WIDTH +: MODULE_WIDTH];

    assign pop        = (skid_cnt_q != 2'd0) && rd_ready;
    assign last_pop   = pop && skid_q[0].meta.last;
    // Reserve a skid slot for the read already in flight so the buffer can never overflow.
    assign occupancy  = 3'(skid_cnt_q) + 3'(pend_valid_q) - 3'(pop);
    assign cur_passes = bank_passes_q[iss_bank_q];
    assign issue      = (occupancy <= 3'd1) &&
                        (iss_active_q || bank_state_q[iss_bank_q] == FULL);
    assign push_word  = '{data: ram_rdata[pend_bank_q], meta: pend_q};

    // NOTE: every variable gets its hold value first so no path through this block infers a latch.
    always_comb begin
        bank_state_d  = bank_state_q;
        bank_passes_d = bank_passes_q;
        beat_d        = beat_q;
        ser_busy_d    = ser_busy_q;
        ser_idx_d     = ser_idx_q;
        wr_ptr_d      = wr_ptr_q;
        wr_bank_d     = wr_bank_q;
        iss_active_d  = iss_active_q;
        iss_addr_d    = iss_addr_q;
        iss_pass_d    = iss_pass_q;
        iss_bank_d    = iss_bank_q;
        rd_bank_d     = rd_bank_q;
        pend_valid_d  = issue;
        pend_d        = pend_q;
        pend_bank_d   = pend_bank_q;
        skid_d        = skid_q;
        skid_cnt_d    = skid_cnt_q;

        if (wr_accept) begin
            beat_d     = wr_data;
            ser_busy_d = 1'b1;
            ser_idx_d  = '0;
            if (bank_state_q[wr_bank_q] == EMPTY) bank_state_d[wr_bank_q] = FILLING;
        end

        if (ser_busy_q) begin
            ser_idx_d = ser_idx_q + SER_W'(1);
            if (ser_idx_q == SER_W'(TOTAL_MODULES - 1)) ser_busy_d = 1'b0;
            if (wr_ptr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                wr_ptr_d                 = '0;
                bank_state_d[wr_bank_q]  = FULL;
                bank_passes_d[wr_bank_q] = PASS_W'(clamp_passes(32'(cfg_passes), MAX_PASSES));
                wr_bank_d                = next_bank(wr_bank_q);
            end else begin
                wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            end
        end

        if (issue) begin
            if (!iss_active_q) bank_state_d[iss_bank_q] = DRAINING;
            iss_active_d = 1'b1;
            pend_bank_d  = iss_bank_q;
            pend_d       = '{addr: iss_addr_q, pass: iss_pass_q,
                             last: (iss_addr_q == ADDR_WIDTH'(DEPTH - 1)) &&
                                   (iss_pass_q == cur_passes - PASS_W'(1))};
            if (iss_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                iss_addr_d = '0;
                if (iss_pass_q == cur_passes - PASS_W'(1)) begin
                    iss_pass_d   = '0;
                    iss_active_d = 1'b0;
                    iss_bank_d   = next_bank(iss_bank_q);
                end else begin
                    iss_pass_d = iss_pass_q + PASS_W'(1);
                end
            end else begin
                iss_addr_d = iss_addr_q + ADDR_WIDTH'(1);
            end
        end

        case ({pend_valid_q, pop})
            2'b01: begin
                skid_d[0]  = skid_q[1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b10: begin
                if (skid_cnt_q == 2'd0) skid_d[0] = push_word;
                else                    skid_d[1] = push_word;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                if (skid_cnt_q == 2'd1) begin
                    skid_d[0] = push_word;
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = push_word;
                end
            end
            default: ;
        endcase

        if (last_pop) begin
            bank_state_d[rd_bank_q] = EMPTY;
            rd_bank_d               = next_bank(rd_bank_q);
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_state_q  <= '{default: EMPTY};
            bank_passes_q <= '{default: '0};
            beat_q        <= '0;
            ser_busy_q    <= 1'b0;
            ser_idx_q     <= '0;
            wr_ptr_q      <= '0;
            wr_bank_q     <= '0;
            iss_active_q  <= 1'b0;
            iss_addr_q    <= '0;
            iss_pass_q    <= '0;
            iss_bank_q    <= '0;
            rd_bank_q     <= '0;
            pend_valid_q  <= 1'b0;
            pend_q        <= '0;
            pend_bank_q   <= '0;
            skid_q        <= '{default: '0};
            skid_cnt_q    <= '0;
        end else begin
            bank_state_q  <= bank_state_d;
            bank_passes_q <= bank_passes_d;
            beat_q        <= beat_d;
            ser_busy_q    <= ser_busy_d;
            ser_idx_q     <= ser_idx_d;
            wr_ptr_q      <= wr_ptr_d;
            wr_bank_q     <= wr_bank_d;
            iss_active_q  <= iss_active_d;
            iss_addr_q    <= iss_addr_d;
            iss_pass_q    <= iss_pass_d;
            iss_bank_q    <= iss_bank_d;
            rd_bank_q     <= rd_bank_d;
            pend_valid_q  <= pend_valid_d;
            pend_q        <= pend_d;
            pend_bank_q   <= pend_bank_d;
            skid_q        <= skid_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        pp_bank_ram #(
            .DEPTH  (DEPTH),
            .DATA_W (MODULE_WIDTH)
        ) u_ram (
            .clk     (clk),
            .wr_en   (ser_busy_q && (wr_bank_q == BANK_W'(b))),
            .wr_addr (wr_ptr_q),
            .wr_data (ram_wdata),
            .rd_en   (issue && (iss_bank_q == BANK_W'(b))),
            .rd_addr (iss_addr_q),
            .rd_data (ram_rdata[b])
        );
    end

    always_comb begin
        banks_full = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_state_q[i] == FULL || bank_state_q[i] == DRAINING)
                banks_full = banks_full + (BANK_W + 1)'(1);
        end
    end

    assign rd_valid       = (skid_cnt_q != 2'd0);
    assign rd_data        = skid_q[0].data;
    assign rd_addr        = skid_q[0].meta.addr;
    assign rd_pass        = skid_q[0].meta.pass;
    assign rd_last        = skid_q[0].meta.last && rd_valid;
    assign active_bank_wr = wr_bank_q;
    assign active_bank_rd = rd_bank_q;

endmodule

// File: tb/tb_multi_bank_pp_buffer.sv
// Bench for multi_bank_pp_buffer (DEPTH=8, 4 modules/beat, 2 banks): a bank-level stream model plus directed timing checks.
module tb_multi_bank_pp_buffer;

    localparam int MW    = 32;
    localparam int IW    = 128;
    localparam int DEP   = 8;
    localparam int TM    = 4;
    localparam int NB    = 2;
    localparam int MAXP  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [IW-1:0] wr_data = '0;
    logic [2:0]    cfg_passes = 3'd1;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [MW-1:0] rd_data;
    logic [2:0]    rd_addr;
    logic [2:0]    rd_pass;
    logic          rd_last;
    logic          active_bank_wr;
    logic          active_bank_rd;
    logic [1:0]    banks_full;

    multi_bank_pp_buffer #(
        .WIDTH (16), .CHUNK_SIZE (1), .NUM_CORES_A (2), .NUM_CORES_B (1),
        .TOTAL_MODULES (TM), .DEPTH (DEP), .NUM_BANKS (NB), .MAX_PASSES (MAXP)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .wr_valid (wr_valid), .wr_ready (wr_ready), .wr_data (wr_data),
        .cfg_passes (cfg_passes),
        .rd_valid (rd_valid), .rd_ready (rd_ready), .rd_data (rd_data),
        .rd_addr (rd_addr), .rd_pass (rd_pass), .rd_last (rd_last),
        .active_bank_wr (active_bank_wr), .active_bank_rd (active_bank_rd),
        .banks_full (banks_full)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] pack(input logic [31:0] d, input logic [2:0] a,
                                         input logic [2:0] p, input logic l, input logic b);
        return {24'b0, b, l, p, a, d};
    endfunction

    // Model: every completed bank expands into its full output stream the moment its last beat is accepted.
    logic [63:0] exp_q[$];
    logic [31:0] fill_buf [DEP];
    int          fill_cnt = 0;
    int          bank_cnt = 0;
    int          win_cnt = 0;
    time         t_first = 0, t_last = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            fill_cnt = 0;
            bank_cnt = 0;
        end else begin
            if (wr_valid && wr_ready) begin
                for (int k = 0; k < TM; k++) fill_buf[fill_cnt + k] = wr_data[k*MW +: MW];
                fill_cnt += TM;
                if (fill_cnt == DEP) begin
                    int n;
                    n = (cfg_passes == 0) ? 1 : ((cfg_passes > MAXP) ? MAXP : int'(cfg_passes));
                    for (int p = 0; p < n; p++)
                        for (int a = 0; a < DEP; a++)
                            exp_q.push_back(pack(fill_buf[a], 3'(a), 3'(p),
                                                 (p == n - 1) && (a == DEP - 1), 1'(bank_cnt % NB)));
                    bank_cnt++;
                    fill_cnt = 0;
                end
            end
            if (rd_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_word", 64'(rd_data), 64'hffff_ffff_ffff_ffff);
                end else if (rd_ready) begin
                    check("rd_word", pack(rd_data, rd_addr, rd_pass, rd_last, active_bank_rd), exp_q.pop_front());
                    if (win_cnt == 0) t_first = $time;
                    t_last = $time;
                    win_cnt++;
                end else begin
                    check("rd_hold", pack(rd_data, rd_addr, rd_pass, rd_last, active_bank_rd), exp_q[0]);
                end
            end
        end
    end

    function automatic logic [IW-1:0] mk_beat(input int base);
        logic [IW-1:0] b;
        for (int k = 0; k < TM; k++) b[k*MW +: MW] = 32'(base + k);
        return b;
    endfunction

    // Entered and left just after a rising edge; returns the sample time of the accepting cycle.
    task automatic send_beat(input logic [IW-1:0] d, output time t_acc);
        int c = 0;
        wr_valid = 1'b1;
        wr_data  = d;
        do begin
            @(negedge clk);
            c++;
        end while (!wr_ready && c < 200);
        if (!wr_ready) check("send_timeout", 64'(c), 64'd0);
        t_acc = $time;
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic fill(input int base, output time t0, output time t1);
        send_beat(mk_beat(base), t0);
        send_beat(mk_beat(base + TM), t1);
    endtask

    task automatic wait_idle();
        int c = 0;
        rd_ready = 1'b1;
        while ((exp_q.size() != 0 || rd_valid) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic new_window();
        win_cnt = 0;
        t_first = 0;
        t_last  = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        time t0, t1, t_dummy;
        int  c;
        logic seen;

        // Reset state
        repeat (2) @(negedge clk);
        check("reset_outputs", {19'b0, wr_ready, rd_valid, rd_data, rd_addr, rd_pass, rd_last,
                                active_bank_wr, active_bank_rd, banks_full}, 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_reset", 64'(wr_ready), 64'd1);
        @(posedge clk); #1;

        // Single fill: words 0..7, one pass
        cfg_passes = 3'd1; rd_ready = 1'b1; new_window();
        fill(0, t0, t1);
        check("beat_spacing", 64'((t1 - t0) / 10), 64'd5);
        c = 0;
        while (win_cnt == 0 && c < 50) begin @(negedge clk); c++; end
        check("first_valid_latency", 64'((t_first - t1) / 10), 64'd7);
        wait_idle();
        check("single_count", 64'(win_cnt), 64'd8);
        check("single_span", 64'((t_last - t_first) / 10), 64'd7);

        // Replay three passes, no bubbles
        cfg_passes = 3'd3; new_window();
        fill(16, t0, t1);
        wait_idle();
        check("replay_count", 64'(win_cnt), 64'd24);
        check("replay_span", 64'((t_last - t_first) / 10), 64'd23);

        // Backpressure: both banks full, writer must stall
        cfg_passes = 3'd1; rd_ready = 1'b0; new_window();
        fill(200, t0, t1);
        fill(208, t0, t1);
        wr_valid = 1'b1; wr_data = mk_beat(300);
        repeat (12) @(negedge clk);
        check("bp_wr_ready", 64'(wr_ready), 64'd0);
        check("bp_banks_full", 64'(banks_full), 64'd2);
        @(posedge clk); #1 rd_ready = 1'b1;
        seen = 1'b0; c = 0;
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            if (rd_valid && rd_ready && rd_last) seen = 1'b1;
        end
        check("bp_last_seen", 64'(seen), 64'd1);
        check("bp_ready_at_last", 64'(wr_ready), 64'd0);
        @(negedge clk);
        check("bp_ready_after_last", 64'(wr_ready), 64'd1);
        @(posedge clk); #1 wr_valid = 1'b0;
        send_beat(mk_beat(304), t_dummy);
        wait_idle();
        check("bp_count", 64'(win_cnt), 64'd24);

        // Clamping of the replay count
        cfg_passes = 3'd0; new_window();
        fill(40, t0, t1);
        wait_idle();
        check("clamp0_count", 64'(win_cnt), 64'd8);
        cfg_passes = 3'd7; new_window();
        fill(60, t0, t1);
        wait_idle();
        check("clamp7_count", 64'(win_cnt), 64'd32);

        // Reset in the middle of a drain
        cfg_passes = 3'd2; rd_ready = 1'b1;
        fill(400, t0, t1);
        seen = 1'b0; c = 0;
        while (!seen && c < 100) begin
            @(negedge clk);
            c++;
            if (rd_valid && rd_ready && rd_pass == 3'd1 && rd_addr == 3'd5) seen = 1'b1;
        end
        check("mid_drain_reached", 64'(seen), 64'd1);
        #2 rst_n = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
        #1;
        check("midreset_outputs", {19'b0, wr_ready, rd_valid, rd_data, rd_addr, rd_pass, rd_last,
                                   active_bank_wr, active_bank_rd, banks_full}, 64'd0);
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check("wr_ready_after_midreset", 64'(wr_ready), 64'd1);
        @(posedge clk); #1;
        cfg_passes = 3'd1; rd_ready = 1'b1; new_window();
        fill(500, t0, t1);
        wait_idle();
        check("post_reset_count", 64'(win_cnt), 64'd8);

        // Random stress over 50 banks
        cfg_passes = 3'd2; new_window();
        c = 0;
        for (int cyc = 0; cyc < 20000 && c < 100; cyc++) begin
            rd_ready = ($urandom_range(0, 2) != 0);
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (wr_valid && wr_ready) c++;
            @(posedge clk); #1;
        end
        wr_valid = 1'b0;
        check("stress_beats", 64'(c), 64'd100);
        wait_idle();
        check("stress_count", 64'(win_cnt), 64'd800);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
